io_dir_sequencer: RTL
=====================

Name: io_dir_sequencer

Overview:
Controller that owns the `pin_dir` vector feeding the IO filter.
It reconfigures pin directions glitch-free in response to a config handshake. Pins turning to input are released first, then a programmable bus-turnaround gap elapses. Only then are pins turning to output switched and their output enables raised.
It sits between the CPU-side config logic and the IO filter / pad ring, and guarantees that no pin is ever driven while its direction is in transition.

Parameters:
TURN_CYCLES, 2, turnaround gap in clock cycles between releasing and applying (0..15).
CNT_W, 4, width of the gap counter; must hold TURN_CYCLES.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset; asynchronous, active-low.
cfg_valid  input  1  new direction request valid.
cfg_ready  output  1  block can accept a request; high only in IDLE.
cfg_dir  input  `IO_PINS  requested direction per pin (0=input, 1=output).
pin_dir  output  `IO_PINS  current direction to the IO filter (0=input, 1=output); registered.
pin_oe  output  `IO_PINS  per-pin output enable for the pad drivers; registered.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse when a request completes.

Behaviour:
- Reset (async, rst_n=0) forces, immediately and independent of clk:
  - state=IDLE, pin_dir=0, pin_oe=0, done=0, counter=0, target register=0.
  - cfg_ready=1 and busy=0 follow from IDLE.
- Reset asserted mid-sequence aborts it. All pins return to input and no done pulse is produced.
- Invariant at all times: pin_oe & ~pin_dir == 0. An enable is never raised on a pin that is not an output.
- Accept: a request is accepted on a rising edge where cfg_valid=1 and cfg_ready=1 (this edge is E0). cfg_dir is latched into the target register at E0.
- Derived masks (from the latched target and pin_dir at E0):
  - to_in = pin_dir & ~target.
  - to_out = ~pin_dir & target.
- No-change request (target == pin_dir):
  - State stays IDLE; done=1 for the cycle after E0.
  - cfg_ready stays high, so back-to-back requests are accepted every cycle.
- Change request: at E0, state<=RELEASE.
- State RELEASE (edge E1):
  - pin_oe <= pin_oe & ~to_in; pin_dir <= pin_dir & ~to_in.
  - Pins in to_out are untouched (remain inputs, oe=0).
  - If TURN_CYCLES=0, state<=APPLY. Otherwise counter<=TURN_CYCLES and state<=GAP.
- State GAP: counter decrements each edge. On the edge where counter==1, state<=APPLY. GAP lasts exactly TURN_CYCLES cycles.
- State APPLY: pin_dir <= target; state<=ENABLE.
- State ENABLE: pin_oe <= target; done<=1 (one cycle); state<=IDLE.
- Timing from E0:
  - released pins go input after E1.
  - pin_dir==target after E(2+TURN_CYCLES).
  - pin_oe==target and done high after E(3+TURN_CYCLES).
  - cfg_ready high again after E(3+TURN_CYCLES).
- Pins unchanged by the request (in neither mask) keep pin_dir and pin_oe constant throughout.
- Requests with cfg_valid=1 while busy are not accepted. The requester holds cfg_valid/cfg_dir; the new cfg_dir is sampled only at the accepting edge.
- cfg_dir changes while busy have no effect on the sequence in progress.
- busy = (state != IDLE); cfg_ready = ~busy. Both are decoded from the state register and are glitch-free.

Test Plan:
- Reset → all outputs 0, cfg_ready=1. Assert rst_n=0 mid-GAP with pin_dir partially released → pin_dir=0 and pin_oe=0 immediately; no done pulse.
- From reset, TURN_CYCLES=2, cfg_dir=8'b0000_1111 → pin_dir=0x0F after E4; pin_oe=0x0F and done pulse after E5; pin_oe=0 before E5.
- From pin_dir=pin_oe=0x0F, request 0xF0 → after E1 pin_dir=pin_oe=0x00; after E4 pin_dir=0xF0; after E5 pin_oe=0xF0. Invariant holds every cycle.
- Request 0x0F while pin_dir=0x0F → done the cycle after E0, busy never high. Back-to-back request 0x0F next cycle is accepted.
- cfg_valid held with 0x33 while busy on a 0x0F request → not accepted until cfg_ready returns. Then the 0x33 sequence runs: to_in=0x0C, to_out=0x30, pins 0 and 1 stay driven throughout.
- TURN_CYCLES=0 build: request 0x01 from 0x00 → pin_dir=0x01 after E2; pin_oe=0x01 and done after E3.

Source files
------------

// File: rtl/io_dir_sequencer_if.sv
// Config handshake between the CPU-side direction request logic and io_dir_sequencer.
`ifndef IO_PINS
`define IO_PINS 8
`endif

interface io_dir_sequencer_if;
    // valid/ready: a request transfers on a rising edge where cfg_valid and cfg_ready are both
    // high; the requester holds cfg_valid and cfg_dir stable until that edge.
    logic                cfg_valid;
    logic                cfg_ready;
    logic [`IO_PINS-1:0] cfg_dir;

    modport master (output cfg_valid, output cfg_dir, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_dir, output cfg_ready);
endinterface

// File: rtl/io_dir_sequencer.sv
// Glitch-free pin direction sequencer: release outgoing drivers, wait a turnaround gap,
// then switch new outputs and only afterwards raise their output enables.
module io_dir_sequencer #(
    parameter int TURN_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    io_dir_sequencer_if.slave   cfg,
    output logic [`IO_PINS-1:0] pin_dir,
    output logic [`IO_PINS-1:0] pin_oe,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RELEASE = 3'd1,
        S_GAP     = 3'd2,
        S_APPLY   = 3'd3,
        S_ENABLE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES);

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [`IO_PINS-1:0] target, target_n;
    logic [`IO_PINS-1:0] dir_n, oe_n;
    logic [`IO_PINS-1:0] to_in;
    logic                done_n;

    assign busy          = (state != S_IDLE);
    assign cfg.cfg_ready = (state == S_IDLE);
    assign state_dbg     = state;

    // pin_dir is frozen between acceptance and RELEASE, so this equals the mask at acceptance.
    assign to_in = pin_dir & ~target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            target  <= '0;
            pin_dir <= '0;
            pin_oe  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            target  <= target_n;
            pin_dir <= dir_n;
            pin_oe  <= oe_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        target_n = target;
        dir_n    = pin_dir;
        oe_n     = pin_oe;
        done_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg.cfg_valid) begin
                    target_n = cfg.cfg_dir;
                    if (cfg.cfg_dir == pin_dir) done_n  = 1'b1;
                    else                        state_n = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Pins heading to output stay inputs with oe low until APPLY/ENABLE.
                oe_n  = pin_oe & ~to_in;
                dir_n = pin_dir & ~to_in;
                if (TURN_CYCLES == 0) begin
                    state_n = S_APPLY;
                end else begin
                    cnt_n   = TURN_LOAD;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) state_n = S_APPLY;
            end
            S_APPLY: begin
                dir_n   = target;
                state_n = S_ENABLE;
            end
            S_ENABLE: begin
                oe_n    = target;
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
